parity_word_packer: RTL
=======================

Name: parity_word_packer

Overview:
Downstream consumer of the 3-bit group-parity stage. It samples the serial parity bit once per strobe, packs W consecutive parity bits into a word, and buffers completed words in a small FIFO. Words leave through a valid/ready handshake toward the bus/logging side. Overflow is flagged, never silently hidden.

Parameters:
W, 8, parity bits per packed word (2..32)
DEPTH, 2, output FIFO entries (power of 2, >=2)

Ports:
C  in  1  clock; all state updates on posedge C
NR  in  1  reset, asynchronous, active-low
D  in  1  group-parity bit from the upstream stage
S  in  1  sample strobe, one-cycle pulse every 3 clocks (cnt3-style); D is valid while S=1
CLR  in  1  synchronous clear of OVF and of the partial word
WORD  out  W  head-of-FIFO word
VALID  out  1  FIFO non-empty
READY  in  1  consumer accepts WORD when VALID&READY at posedge C
OVF  out  1  sticky overflow flag
LVL  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (NR=0, async): bit counter=0, shift reg=0, FIFO empty, VALID=0, WORD=0, OVF=0, LVL=0. Release is synchronous to the next posedge C.
- Capture: at posedge C with S=1, D is written into bit position bitcnt (first bit -> WORD[0], LSB-first). bitcnt increments. With S=0, nothing changes.
- Word complete: the capture at bitcnt=W-1 pushes {D, shreg[W-2:0]} into the FIFO in the same edge. bitcnt wraps to 0.
- Latency: VALID rises on the edge that captures the last bit; WORD is valid from that point. The sample-to-visible delay is 1 clock.
- Pop: at posedge C with VALID&READY, the head advances. WORD/VALID are registered from FIFO state. READY may be held high permanently.
- Push and pop in the same edge: occupancy is unchanged. This is legal even when the FIFO is full, because the pop frees the slot first.
- Full with push and no pop: the word is dropped, OVF is set (sticky), and the FIFO contents are unchanged. bitcnt still wraps to 0.
- CLR=1: OVF=0, bitcnt=0, partial word discarded. The FIFO is untouched. If CLR and S are both high in the same edge, CLR wins and the bit is discarded.
- Empty with READY=1: no effect and no underflow.
- Pointer arithmetic: wrap modulo DEPTH. LVL ranges 0..DEPTH.
- Reset mid-word or mid-handshake: all state is lost immediately and no word is emitted.

Optional Feature:
Macro PACK_WPAR_EN.
- With the macro: an extra output WPAR (1 bit) carries the XOR of WORD. It is stored per FIFO entry alongside the word and is 0 at reset or when empty.
- Without the macro: the port is absent, there is no extra storage, and behaviour is otherwise identical.

Decomposition:
- Shared package: default W and DEPTH constants, $clog2-derived widths, and the occupancy type.
- One sub-module, pwp_fifo: a synchronous FIFO with push, pop, full, empty, level and data out, using the same C/NR. The packer instantiates it.

Test Plan:
1. Reset, then 8 strobes with D=1,0,1,1,0,0,1,0 (first bit first) -> WORD=8'h4D, VALID=1 one clock after the 8th strobe edge, LVL=1.
2. READY=0, pack 3 words (8'hFF, 8'h00, 8'hA5) -> first two buffered with LVL=2. Third dropped and OVF=1. After popping, the words arrive in order FF then 00.
3. FIFO full, READY=1 on the same edge the 3rd word completes -> no drop, OVF=0, LVL stays 2, next WORD=second word.
4. 5 strobes, then pulse CLR, then 8 strobes of D=1 -> WORD=8'hFF (no stale bits) and OVF cleared. CLR together with S discards that bit.
5. Assert NR=0 between clock edges mid-word with a word pending -> VALID, WORD, LVL and OVF are 0 immediately. After release, a fresh 8 bits produce the correct word.
6. With PACK_WPAR_EN, WORD=8'h4D -> WPAR=0; WORD=8'h4C -> WPAR=1. Without the macro, the bench compiles with no WPAR port.

Source files
------------

// File: rtl/parity_word_packer_pkg.sv
// rtl/parity_word_packer_pkg.sv - shared constants, widths and occupancy type for the parity word packer
package parity_word_packer_pkg;

  localparam int PWP_W_DEF     = 8;
  localparam int PWP_DEPTH_DEF = 2;

  // Counter/pointer width for a modulus n; never narrower than one bit.
  function automatic int pwp_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PWP_LVL_W_DEF = pwp_cnt_w(PWP_DEPTH_DEF) + 1;

  typedef logic [PWP_LVL_W_DEF-1:0] pwp_lvl_t;

endpackage

// File: rtl/parity_word_packer_if.sv
// rtl/parity_word_packer_if.sv - output word handshake bundle; WPAR present only with PACK_WPAR_EN
interface parity_word_packer_if
  import parity_word_packer_pkg::*;
#(
  parameter int W     = PWP_W_DEF,
  parameter int DEPTH = PWP_DEPTH_DEF
);

  localparam int LVL_W = pwp_cnt_w(DEPTH) + 1;

  logic [W-1:0]     WORD;
  logic             VALID;
  logic             READY;
  logic             OVF;
  logic [LVL_W-1:0] LVL;
`ifdef PACK_WPAR_EN
  logic             WPAR;

  modport master (output WORD, VALID, OVF, LVL, WPAR, input READY);
  modport slave  (input WORD, VALID, OVF, LVL, WPAR, output READY);
`else
  modport master (output WORD, VALID, OVF, LVL, input READY);
  modport slave  (input WORD, VALID, OVF, LVL, output READY);
`endif

endinterface

// File: rtl/parity_word_packer_fifo.sv
// rtl/parity_word_packer_fifo.sv - pwp_fifo: synchronous FIFO with level, full/empty and zeroed head when empty
module pwp_fifo
  import parity_word_packer_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = PWP_DEPTH_DEF
) (
  input  logic                        C,
  input  logic                        NR,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DW-1:0]               din,
  output logic [DW-1:0]               dout,
  output logic                        full,
  output logic                        empty,
  output logic [pwp_cnt_w(DEPTH):0]   level
);

  localparam int PW = pwp_cnt_w(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the head slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  assign level   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge C or negedge NR) begin
    if (!NR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_word_packer.sv
// rtl/parity_word_packer.sv - packs strobed parity bits LSB-first into W-bit words buffered in pwp_fifo; PACK_WPAR_EN adds per-word XOR output WPAR
module parity_word_packer
  import parity_word_packer_pkg::*;
#(
  parameter int W     = PWP_W_DEF,
  parameter int DEPTH = PWP_DEPTH_DEF
) (
  input  logic                   C,
  input  logic                   NR,
  input  logic                   D,
  input  logic                   S,
  input  logic                   CLR,
  parity_word_packer_if.master   bus
);

  localparam int CNT_W = pwp_cnt_w(W);
  localparam int LVL_W = pwp_cnt_w(DEPTH) + 1;
`ifdef PACK_WPAR_EN
  localparam int DW = W + 1;
`else
  localparam int DW = W;
`endif

  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     push_word;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, empty;
  logic [DW-1:0]    push_data, head_data;
  logic [LVL_W-1:0] level;

  assign pop = bus.READY & ~empty;

  always_comb begin
    bitcnt_d            = bitcnt_q;
    shreg_d             = shreg_q;
    ovf_d               = ovf_q;
    push                = 1'b0;
    push_word           = shreg_q;
    push_word[bitcnt_q] = D;
    if (CLR) begin
      bitcnt_d = '0;
      shreg_d  = '0;
      ovf_d    = 1'b0;
    end else if (S) begin
      if (bitcnt_q == CNT_W'(W - 1)) begin
        push     = 1'b1;
        bitcnt_d = '0;
        shreg_d  = '0;
        // Dropped word: the FIFO ignores the push, only the flag records it.
        if (full && !pop) begin
          ovf_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + CNT_W'(1);
        shreg_d  = push_word;
      end
    end
  end

  always_ff @(posedge C or negedge NR) begin
    if (!NR) begin
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef PACK_WPAR_EN
  assign push_data = {^push_word, push_word};
  assign bus.WPAR  = head_data[W];
`else
  assign push_data = push_word;
`endif

  pwp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .C     (C),
    .NR    (NR),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.WORD  = head_data[W-1:0];
  assign bus.VALID = ~empty;
  assign bus.OVF   = ovf_q;
  assign bus.LVL   = level;

endmodule
